// File: rtl/axi4_slave_mem_pkg.sv
// Shared types for the AXI4 memory responder: burst encodings, response codes, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package axi4_slave_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2,
        RSVD  = 2'd3
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle carrying all five channels between one initiator and one responder.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on every channel; bwvalid/aready naming kept from the BFM.
interface axi4_if #(
    parameter int DATA_BYTES      = 4,
    parameter int ADDR_BYTES      = 1,
    parameter int NUM_ID_BITS_P   = 4,
    parameter int NUM_USER_BITS_P = 4
);
    // write address
    logic [NUM_ID_BITS_P-1:0]   awid;
    logic [8*ADDR_BYTES-1:0]    awaddr;
    logic [7:0]                 awlen;
    logic [2:0]                 awsize;
    logic [1:0]                 awburst;
    logic                       awlock;
    logic [3:0]                 awcache;
    logic [2:0]                 awprot;
    logic [3:0]                 awqos;
    logic [3:0]                 awregion;
    logic [NUM_USER_BITS_P-1:0] awuser;
    logic                       awvalid;
    logic                       awready;
    // write data
    logic [8*DATA_BYTES-1:0]    wdata;
    logic [DATA_BYTES-1:0]      wstrb;
    logic                       wlast;
    logic [NUM_USER_BITS_P-1:0] wuser;
    logic                       wvalid;
    logic                       wready;
    // write response
    logic [NUM_ID_BITS_P-1:0]   bid;
    logic [1:0]                 bresp;
    logic [NUM_USER_BITS_P-1:0] buser;
    logic                       bwvalid;
    logic                       bwready;
    // read address
    logic [NUM_ID_BITS_P-1:0]   arid;
    logic [8*ADDR_BYTES-1:0]    araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic                       arlock;
    logic [3:0]                 arcache;
    logic [2:0]                 arprot;
    logic [3:0]                 arqos;
    logic [3:0]                 arregion;
    logic [NUM_USER_BITS_P-1:0] aruser;
    logic                       arvalid;
    logic                       aready;
    // read data
    logic [NUM_ID_BITS_P-1:0]   rid;
    logic [8*DATA_BYTES-1:0]    rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic [NUM_USER_BITS_P-1:0] ruser;
    logic                       rvalid;
    logic                       rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
               awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bwvalid,
        input  bwready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
               aruser, arvalid,
        output aready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
               awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bwvalid,
        output bwready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
               aruser, arvalid,
        input  aready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts plus error checks on current and next address.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to advance.
// Ports: addr_i/size_i/len_i/burst_i describe the current beat; next_addr_o is the following beat,
//        cur_err_o/next_err_o flag SLVERR conditions for the current and following beat.
module axi4_burst_addr_gen
    import axi4_slave_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_BYTES = 4,
    parameter int MEM_DEPTH  = 64
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              cur_err_o,
    output logic              next_err_o
);
    localparam int          OFF   = $clog2(DATA_BYTES);
    localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

    logic [31:0] a;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] nxt;
    logic        cfg_err;

    always_comb begin
        a   = 32'(addr_i);
        s   = 32'd1 << size_i;
        b   = (32'(len_i) + 32'd1) * s;
        nxt = a;
        // Errors that poison every beat of the burst regardless of address.
        cfg_err = ({29'd0, size_i} > 32'(OFF))
               || (burst_t'(burst_i) == RSVD)
               || ((burst_t'(burst_i) == WRAP) && !(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
        case (burst_t'(burst_i))
            FIXED:   nxt = a;
            WRAP:    nxt = (a & ~(b - 32'd1)) | ((a + s) & (b - 32'd1));
            default: nxt = (a & ~(s - 32'd1)) + s;  // INCR, and RSVD treated as INCR
        endcase
    end

    // Truncation gives the modulo-address-space wrap for INCR.
    assign next_addr_o = nxt[ADDR_W-1:0];
    assign cur_err_o   = cfg_err || ((a >> OFF) >= DEPTH);
    assign next_err_o  = cfg_err || ((32'(next_addr_o) >> OFF) >= DEPTH);

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 responder backed by a register array; independent write and read FSMs, one burst each.
// Latency: wready / rvalid(beat 0) one cycle after the address handshake; bwvalid one cycle after last W.
// Backpressure: rvalid/rdata held while rready=0; bwvalid held until bwready; 1 beat/cycle otherwise.
// Ports: aclk, aresetn (async active-low), axi (axi4_if slave modport, all five channels).
module axi4_slave_mem
    import axi4_slave_mem_pkg::*;
#(
    parameter int DATA_BYTES      = 4,
    parameter int ADDR_BYTES      = 1,
    parameter int NUM_ID_BITS_P   = 4,
    parameter int NUM_USER_BITS_P = 4,
    parameter int MEM_DEPTH       = 64
) (
    input  logic  aclk,
    input  logic  aresetn,
    axi4_if.slave axi
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int ID_W   = NUM_ID_BITS_P;
    localparam int OFF    = $clog2(DATA_BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Out-of-range addresses alias here, but such beats are always masked by the error checks.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] w;
        w = addr >> OFF;
        return w[IDX_W-1:0];
    endfunction

    // ---------------- write path ----------------
    w_state_t          w_state_q;
    logic              awready_q;
    logic              wready_q;
    logic              bwvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [ADDR_W-1:0] waddr_d;
    logic [7:0]        wlen_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic [7:0]        wbeat_q;
    logic              werr_q;
    logic              wg_cur_err;
    logic              wg_next_err;
    logic              w_hs;
    logic              w_last_beat;
    logic              w_beat_err;

    axi4_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_wgen (
        .addr_i      (waddr_q),
        .size_i      (wsize_q),
        .len_i       (wlen_q),
        .burst_i     (wburst_q),
        .next_addr_o (waddr_d),
        .cur_err_o   (wg_cur_err),
        .next_err_o  (wg_next_err)
    );

    assign w_hs        = (w_state_q == W_DATA) && wready_q && axi.wvalid;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign w_beat_err  = wg_cur_err || (axi.wlast != w_last_beat);

    always_ff @(posedge aclk) begin
        if (w_hs && !w_beat_err) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (axi.wstrb[b]) begin
                    mem[word_idx(waddr_q)][8*b +: 8] <= axi.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bwvalid_q <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    // awready rises one cycle after entering IDLE: that is the idle gap.
                    awready_q <= 1'b1;
                    if (axi.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= axi.awid;
                        waddr_q   <= axi.awaddr;
                        wlen_q    <= axi.awlen;
                        wsize_q   <= axi.awsize;
                        wburst_q  <= axi.awburst;
                        wbeat_q   <= '0;
                        werr_q    <= 1'b0;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        werr_q  <= werr_q || w_beat_err;
                        waddr_q <= waddr_d;
                        wbeat_q <= wbeat_q + 8'd1;
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bwvalid_q <= 1'b1;
                            bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi.bwready) begin
                        bwvalid_q <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bwvalid = bwvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.bid     = bid_q;
    assign axi.buser   = '0;

    // ---------------- read path ----------------
    r_state_t          r_state_q;
    logic              aready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [1:0]        rresp_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ID_W-1:0]   rid_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] raddr_d;
    logic [7:0]        rlen_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic [7:0]        rbeat_q;
    logic [ADDR_W-1:0] rg_addr;
    logic [2:0]        rg_size;
    logic [7:0]        rg_len;
    logic [1:0]        rg_burst;
    logic              rg_cur_err;
    logic              rg_next_err;

    // In IDLE the generator looks at the AR channel so beat 0 can be loaded on the handshake;
    // afterwards it walks the latched burst.
    always_comb begin
        rg_addr  = raddr_q;
        rg_size  = rsize_q;
        rg_len   = rlen_q;
        rg_burst = rburst_q;
        if (r_state_q == R_IDLE) begin
            rg_addr  = axi.araddr;
            rg_size  = axi.arsize;
            rg_len   = axi.arlen;
            rg_burst = axi.arburst;
        end
    end

    axi4_burst_addr_gen #(
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_rgen (
        .addr_i      (rg_addr),
        .size_i      (rg_size),
        .len_i       (rg_len),
        .burst_i     (rg_burst),
        .next_addr_o (raddr_d),
        .cur_err_o   (rg_cur_err),
        .next_err_o  (rg_next_err)
    );

    // mem is written with <= elsewhere, so a same-cycle read here sees the old word.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            aready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    aready_q <= 1'b1;
                    if (axi.arvalid && aready_q) begin
                        aready_q  <= 1'b0;
                        rid_q     <= axi.arid;
                        raddr_q   <= axi.araddr;
                        rlen_q    <= axi.arlen;
                        rsize_q   <= axi.arsize;
                        rburst_q  <= axi.arburst;
                        rbeat_q   <= '0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (axi.arlen == 8'd0);
                        rdata_q   <= rg_cur_err ? '0 : mem[word_idx(rg_addr)];
                        rresp_q   <= rg_cur_err ? RESP_SLVERR : RESP_OKAY;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            r_state_q <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_d;
                            rbeat_q <= rbeat_q + 8'd1;
                            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                            rdata_q <= rg_next_err ? '0 : mem[word_idx(raddr_d)];
                            rresp_q <= rg_next_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign axi.aready = aready_q;
    assign axi.rvalid = rvalid_q;
    assign axi.rlast  = rlast_q;
    assign axi.rresp  = rresp_q;
    assign axi.rdata  = rdata_q;
    assign axi.rid    = rid_q;
    assign axi.ruser  = '0;

    // Attribute and user fields carry no meaning for this memory.
    logic unused_attr;
    assign unused_attr = ^{axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion,
                           axi.awuser, axi.wuser, axi.arlock, axi.arcache, axi.arprot,
                           axi.arqos, axi.arregion, axi.aruser};

endmodule

// File: tb/tb_axi4_slave_mem.sv
module tb_axi4_slave_mem;
    import axi4_slave_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_if #(.DATA_BYTES(4), .ADDR_BYTES(1), .NUM_ID_BITS_P(4), .NUM_USER_BITS_P(4)) axi ();

    axi4_slave_mem #(
        .DATA_BYTES      (4),
        .ADDR_BYTES      (1),
        .NUM_ID_BITS_P   (4),
        .NUM_USER_BITS_P (4),
        .MEM_DEPTH       (32)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .axi     (axi.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    logic [31:0] wbuf [16];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        total++;
        bad++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] r, input logic l, input logic [3:0] id);
        rexp_t e;
        e.data = d; e.resp = r; e.last = l; e.id = id;
        rq.push_back(e);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic aw_send(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int n = 0;
        axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2; axi.awburst = burst;
        axi.awid = id; axi.awvalid = 1'b1;
        @(negedge clk);
        while (axi.awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("aw_handshake");
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        chk("wready_after_aw", axi.wready, 1);
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
        int n = 0;
        axi.wdata = d; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        @(negedge clk);
        while (axi.wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("w_handshake");
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
    endtask

    task automatic b_wait(input int hold);
        bexp_t e;
        int n = 0;
        chk("bwvalid_after_last", axi.bwvalid, 1);
        axi.bwready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("bwvalid_held", axi.bwvalid, 1);
        end
        axi.bwready = 1'b1;
        @(negedge clk);
        while (axi.bwvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("b_handshake");
        else if (bq.size() == 0) tmo("b_unexpected");
        else begin
            e = bq.pop_front();
            chk("bresp", 32'(axi.bresp), 32'(e.resp));
            chk("bid", 32'(axi.bid), 32'(e.id));
        end
        @(posedge clk); #1;
        axi.bwready = 1'b0;
        chk("bwvalid_clear", axi.bwvalid, 0);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input logic [1:0] resp, input int hold,
                            input bit bad_wlast0, input logic [3:0] strb);
        bexp_t e;
        e.resp = resp; e.id = id;
        bq.push_back(e);
        aw_send(addr, len, burst, id);
        for (int i = 0; i <= int'(len); i++)
            w_beat(wbuf[i], strb, (i == int'(len)) || (bad_wlast0 && i == 0));
        b_wait(hold);
    endtask

    task automatic ar_send(input logic [7:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int n = 0;
        axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2; axi.arburst = burst;
        axi.arid = id; axi.arvalid = 1'b1;
        @(negedge clk);
        while (axi.aready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) tmo("ar_handshake");
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        chk("rvalid_after_ar", axi.rvalid, 1);
    endtask

    task automatic r_collect(input int nbeats, input bit toggle);
        rexp_t e;
        int got = 0;
        int cyc = 0;
        bit ph = 1'b0;
        bit held = 1'b0;
        logic [31:0] hd = '0;
        while (got < nbeats && cyc < 200) begin
            axi.rready = toggle ? ph : 1'b1;
            ph = ~ph;
            @(negedge clk);
            if (held) begin
                chk("rvalid_stable", axi.rvalid, 1);
                chk("rdata_stable", axi.rdata, hd);
                held = 1'b0;
            end
            if (axi.rvalid === 1'b1) begin
                if (axi.rready) begin
                    if (rq.size() == 0) tmo("r_unexpected");
                    else begin
                        e = rq.pop_front();
                        chk("rdata", axi.rdata, e.data);
                        chk("rresp", 32'(axi.rresp), 32'(e.resp));
                        chk("rlast", 32'(axi.rlast), 32'(e.last));
                        chk("rid", 32'(axi.rid), 32'(e.id));
                    end
                    got++;
                end else begin
                    held = 1'b1;
                    hd = axi.rdata;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        axi.rready = 1'b0;
        if (got < nbeats) tmo("r_beats");
        chk("rvalid_done", axi.rvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0; axi.awregion = '0;
        axi.awuser = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wuser = '0; axi.wvalid = 1'b0;
        axi.bwready = 1'b0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.arlock = '0; axi.arcache = '0; axi.arprot = '0; axi.arqos = '0; axi.arregion = '0;
        axi.aruser = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", axi.awready, 0);
        chk("rst_aready", axi.aready, 0);
        chk("rst_wready", axi.wready, 0);
        chk("rst_bwvalid", axi.bwvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_rdata", axi.rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("awready_after_release", axi.awready, 1);
        chk("aready_after_release", axi.aready, 1);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(8'h10, 8'd3, INCR, 4'h3, RESP_OKAY, 0, 1'b0, 4'hF);
        for (int i = 0; i < 4; i++) push_r(32'hA0 + 32'(i), RESP_OKAY, i == 3, 4'h5);
        ar_send(8'h10, 8'd3, INCR, 4'h5);
        r_collect(4, 1'b0);

        // WRAP read starting mid-block: 0x38, 0x3C, 0x30, 0x34
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + 32'(i);
        do_write(8'h30, 8'd3, INCR, 4'h1, RESP_OKAY, 0, 1'b0, 4'hF);
        push_r(32'hD2, RESP_OKAY, 1'b0, 4'h2);
        push_r(32'hD3, RESP_OKAY, 1'b0, 4'h2);
        push_r(32'hD0, RESP_OKAY, 1'b0, 4'h2);
        push_r(32'hD1, RESP_OKAY, 1'b1, 4'h2);
        ar_send(8'h38, 8'd3, WRAP, 4'h2);
        r_collect(4, 1'b0);

        // Narrow write into a zeroed word
        wbuf[0] = 32'h0;
        do_write(8'h00, 8'd0, INCR, 4'h1, RESP_OKAY, 0, 1'b0, 4'hF);
        wbuf[0] = 32'hFFFF_FFFF;
        do_write(8'h00, 8'd0, INCR, 4'h1, RESP_OKAY, 0, 1'b0, 4'b0100);
        push_r(32'h00FF_0000, RESP_OKAY, 1'b1, 4'h7);
        ar_send(8'h00, 8'd0, INCR, 4'h7);
        r_collect(1, 1'b0);

        // Out of range: word 32 of a 32-word memory; word 0 must not be disturbed
        wbuf[0] = 32'h1234_5678;
        do_write(8'h80, 8'd0, INCR, 4'h4, RESP_SLVERR, 0, 1'b0, 4'hF);
        push_r(32'h00FF_0000, RESP_OKAY, 1'b1, 4'h8);
        ar_send(8'h00, 8'd0, INCR, 4'h8);
        r_collect(1, 1'b0);
        push_r(32'h0, RESP_SLVERR, 1'b1, 4'h9);
        ar_send(8'h80, 8'd0, INCR, 4'h9);
        r_collect(1, 1'b0);

        // Early wlast: beat 0 is dropped and flagged, beat 1 still lands
        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        do_write(8'h60, 8'd1, INCR, 4'hA, RESP_OKAY, 0, 1'b0, 4'hF);
        wbuf[0] = 32'h33; wbuf[1] = 32'h44;
        do_write(8'h60, 8'd1, INCR, 4'hB, RESP_SLVERR, 0, 1'b1, 4'hF);
        push_r(32'h11, RESP_OKAY, 1'b0, 4'hC);
        push_r(32'h44, RESP_OKAY, 1'b1, 4'hC);
        ar_send(8'h60, 8'd1, INCR, 4'hC);
        r_collect(2, 1'b0);

        // Backpressure: B held off 5 cycles, R accepted every other cycle
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hE0 + 32'(i);
        do_write(8'h40, 8'd7, INCR, 4'h8, RESP_OKAY, 5, 1'b0, 4'hF);
        for (int i = 0; i < 8; i++) push_r(32'hE0 + 32'(i), RESP_OKAY, i == 7, 4'hD);
        ar_send(8'h40, 8'd7, INCR, 4'hD);
        r_collect(8, 1'b1);

        // Reset while beat 2 of a len=7 write is on the bus
        aw_send(8'h40, 8'd7, INCR, 4'h6);
        w_beat(32'hC0, 4'hF, 1'b0);
        w_beat(32'hC1, 4'hF, 1'b0);
        axi.wdata = 32'hC2; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_awready", axi.awready, 0);
        chk("midrst_wready", axi.wready, 0);
        chk("midrst_bwvalid", axi.bwvalid, 0);
        chk("midrst_aready", axi.aready, 0);
        chk("midrst_rvalid", axi.rvalid, 0);
        axi.wvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("awready_after_midrst", axi.awready, 1);
        chk("bwvalid_after_midrst", axi.bwvalid, 0);
        push_r(32'hC0, RESP_OKAY, 1'b0, 4'hE);
        push_r(32'hC1, RESP_OKAY, 1'b0, 4'hE);
        for (int i = 2; i < 8; i++) push_r(32'hE0 + 32'(i), RESP_OKAY, i == 7, 4'hE);
        ar_send(8'h40, 8'd7, INCR, 4'hE);
        r_collect(8, 1'b0);

        chk("scoreboard_r_empty", 32'(rq.size()), 0);
        chk("scoreboard_b_empty", 32'(bq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
